// File: rtl/kbd_ps2_rx.sv
// PS/2 device-to-host frame receiver with a first-word-fall-through scan-code FIFO.
// Frames are checked for odd parity and stop bit before they are queued for the core.
module kbd_ps2_rx #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       kbd_read_enable,
  output logic       kbd_ready,
  output logic [7:0] kbd_data,
  output logic       kbd_overflow,
  output logic       kbd_frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          data_s1_q, data_s2_q;
  logic          fe_s;
  state_t        state_q, state_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_ok_s, push_s, frame_bad_s;
  logic          frame_err_q;

  logic [7:0]    mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          empty_s, full_s, pop_s, wr_en_s, ovf_set_s;
  logic          ovf_q, ovf_d;

  // Pin synchronisers; idle-high reset so a held-high line never looks like an edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data;
      data_s2_q  <= data_s1_q;
    end
  end

  assign fe_s = ~clk_s2_q & clk_prev_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Receive datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      bitcnt_q <= 4'd0;
      shift_q  <= 10'd0;
      tmo_q    <= '0;
    end else begin
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      tmo_q    <= tmo_d;
    end
  end

  // FSM next state; an edge in RECV takes priority over an expiring timeout
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    tmo_d    = tmo_q;
    case (state_q)
      IDLE: begin
        if (fe_s && !data_s2_q) begin
          state_d  = RECV;
          bitcnt_d = 4'd0;
          tmo_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RECV: begin
        if (fe_s) begin
          shift_d  = {data_s2_q, shift_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          tmo_d    = '0;
          if (bitcnt_q == 4'd9) begin
            state_d = CHECK;
          end else begin
            state_d = RECV;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs: shift_q holds {stop, parity, data[7:0]} while in CHECK
  always_comb begin
    frame_ok_s  = ((^shift_q[7:0]) ^ shift_q[8]) & shift_q[9];
    push_s      = 1'b0;
    frame_bad_s = 1'b0;
    if (state_q == CHECK) begin
      push_s      = frame_ok_s;
      frame_bad_s = ~frame_ok_s;
    end else begin
      push_s      = 1'b0;
      frame_bad_s = 1'b0;
    end
  end

  assign empty_s   = (wr_ptr_q == rd_ptr_q);
  assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_s     = kbd_read_enable & ~empty_s;
  assign wr_en_s   = push_s & (~full_s | pop_s);
  assign ovf_set_s = push_s & full_s & ~pop_s;

  // FIFO pointer and sticky overflow next state; a new drop beats a clearing pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (pop_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO control and flag registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ovf_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ovf_q       <= ovf_d;
      frame_err_q <= frame_bad_s;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate every read
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shift_q[7:0];
    end
  end

  assign kbd_ready     = ~empty_s;
  assign kbd_data      = empty_s ? 8'd0 : mem_q[rd_ptr_q[AW-1:0]];
  assign kbd_overflow  = ovf_q;
  assign kbd_frame_err = frame_err_q;

endmodule

// File: doc/kbd_ps2_rx.md
# kbd_ps2_rx

PS/2 keyboard receiver and scan-code FIFO; the device side of the CPU's keyboard MMIO port. Deserialises 11-bit PS/2 device-to-host frames from the raw `ps2_clk` and `ps2_data` pins, then validates start, parity and stop bits. Valid bytes are buffered in a first-word-fall-through FIFO. Presents `kbd_ready`, `kbd_data` and `kbd_overflow` to the core and consumes its `kbd_read_enable` pop strobe.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 100000: clk cycles without a PS/2 falling edge before a partial frame is discarded (2 ms at 50 MHz).

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous, idle high.
- `ps2_data`  in  1  raw PS/2 data, asynchronous, idle high.
- `kbd_read_enable`  in  1  pop strobe from the core; sampled at the rising edge.
- `kbd_ready`  out  1  FIFO non-empty.
- `kbd_data`  out  8  FIFO head byte; combinational from storage; 0 when empty.
- `kbd_overflow`  out  1  sticky flag; a valid byte was dropped because the FIFO was full.
- `kbd_frame_err`  out  1  one-cycle pulse; a frame failed its parity or stop check.

## Operation
- **Input sync:** both pins pass through 2-flop synchronisers, plus one history flop on the clock path. These flops reset to 1.
  - Falling edge (`fe`) = `clk_sync==0 && clk_prev==1`.
  - Data is sampled from `data_sync` in the same cycle as `fe`.
- **FSM states:** IDLE, RECV, CHECK.
  - IDLE: on `fe` with data 0 (start bit), clear the bit counter and go to RECV. On `fe` with data 1, stay in IDLE (glitch filter).
  - RECV: on each `fe`, shift data into a 10-bit shift register, LSB first: 8 data bits, then parity, then stop. After the 10th shift, go to CHECK.
  - CHECK (exactly one cycle): the frame is valid if `^data ^ parity == 1` (odd parity) and stop == 1.
    - Valid: push the byte.
    - Invalid: pulse `kbd_frame_err` and do not push.
    - Always return to IDLE.
- **Timeout:** in RECV the counter increments each cycle and clears on `fe`. When it reaches TIMEOUT_CYCLES−1, discard the partial frame, go to IDLE, and raise no error.
- **FIFO:** read/write pointers of `$clog2(DEPTH)+1` bits.
  - full = pointer MSBs differ and the low bits are equal.
  - empty = pointers equal.
- **Pop:** occurs when `kbd_read_enable && kbd_ready`. Pop while empty is ignored; pointers do not change.
- **Push:** a valid CHECK pushes if not full, or if full and a pop occurs in the same cycle.
  - Push when full with no pop: drop the byte, set `kbd_overflow`.
  - Simultaneous push and pop on an empty FIFO: push only.
- **`kbd_overflow` clearing:** cleared by any pop. If a set event and a clearing pop occur in the same cycle, set wins.
- **Reset:** returns to IDLE and clears the pointers, counters and flags. FIFO contents are don't-care.

## Timing
- Reset values: `kbd_ready`=0, `kbd_data`=0, `kbd_overflow`=0, `kbd_frame_err`=0.
- Pin-to-`fe` latency: 3 clk cycles after `ps2_clk` falls.
- Frame completion to `kbd_ready`:
  - cycle t: `fe` of the stop bit; shift occurs at the end of t.
  - t+1: CHECK; FIFO write at the end of t+1.
  - t+2: `kbd_ready`=1 and `kbd_data` is valid.
- `kbd_frame_err` is high during t+2 only.
- Pop latency: `kbd_data` shows the head during the same cycle `kbd_read_enable` is high (single-cycle load). The next entry, or `kbd_ready`=0, appears the following cycle.
- Throughput: one byte per frame; there is no back-pressure to the keyboard.
- Reset mid-frame: the partial frame is lost. The next start bit is accepted only after reset deasserts, once the synchronisers observe `ps2_clk` high.

## Test plan
- **Single byte:** send frame 0x1C (parity 0, stop 1) at 12.5 kHz → `kbd_ready`=1 exactly 2 cycles after the stop-bit `fe`, `kbd_data`=0x1C. Pulse `kbd_read_enable` for 1 cycle → `kbd_ready`=0 the next cycle.
- **Parity error:** send 0x1C with parity 1 → one-cycle `kbd_frame_err`, `kbd_ready` stays 0. A following valid 0xF0 is received correctly.
- **Overflow:** with DEPTH=8, send 9 bytes 0x01..0x09 with no reads → `kbd_overflow`=1. Eight pops return 0x01..0x08; `kbd_overflow` clears on the first pop.
- **Full, simultaneous push and pop:** fill the FIFO, then assert `kbd_read_enable` in the CHECK cycle of byte 0x55 → no overflow, `kbd_ready` stays 1, 0x55 is the last byte out.
- **Timeout and glitch:**
  - Drive a start bit plus 4 bits, then hold for TIMEOUT_CYCLES → no push and no error. A subsequent full 0x2A frame is received as 0x2A.
  - A lone `fe` with data 1 in IDLE is ignored.
- **Reset and empty pop:**
  - Assert `rst`=0 for 1 cycle mid-frame and after 3 queued bytes → all outputs 0, no stale data.
  - `kbd_read_enable` while empty leaves the pointers unchanged.
